instruction_fetch: RTL and testbench
====================================

// Module: instruction_fetch
// PURPOSE
//  Instruction sequencer that feeds the ControlUnit. Holds the program counter,
//  fetches 8-bit instructions from instruction memory over a req/ack handshake,
//  and presents each one on inst with instValid until the decode stage takes it.
//  Whenever no instruction is valid, inst drives 8'h00 (NOP), so the ControlUnit
//  decodes to all-zero control signals.
// PARAMETERS
//  ADDR_W    8     width of the program counter and memAddr
//  PC_RESET  0     PC value loaded on reset (ADDR_W bits)
// PORTS
//  clk         in   1       clock, rising edge
//  rstN        in   1       asynchronous reset, active-low
//  memAddr     out  ADDR_W  instruction memory address (= PC while memReq)
//  memReq      out  1       fetch request to instruction memory
//  memAck      in   1       memory ack; memData valid in the same cycle
//  memData     in   8       instruction byte from memory
//  inst        out  8       instruction to ControlUnit; 8'h00 when !instValid
//  instValid   out  1       inst holds a fetched instruction
//  instTaken   in   1       decode stage consumes inst this cycle
//  branch      in   1       redirect PC; sampled only with instValid&&instTaken
//  branchAddr  in   ADDR_W  redirect target
//  halted      out  1       fetch stopped (HALT_EN only; tied 0 otherwise)
// BEHAVIOUR
//  Reset (rstN=0, async): state=REQ, pc=PC_RESET, instReg=8'h00,
//   memReq=0, instValid=0, inst=8'h00, halted=0, memAddr=PC_RESET.
//   memReq is forced low combinationally while rstN=0, including mid-fetch;
//   any in-flight fetch is abandoned.
//  States: REQ, VALID, HALT (HALT only with HALT_EN).
//  REQ: memReq=1, memAddr=pc, both held stable until memAck.
//   On a clk edge with memReq&&memAck: instReg<=memData, pc<=pc+1, ->VALID.
//   Zero-wait memory (ack in first REQ cycle) is legal. Minimum latency is
//   memReq rise to instValid = 1 cycle.
//  VALID: memReq=0, instValid=1, inst=instReg.
//   instTaken=0: hold; instReg and pc unchanged.
//   instTaken=1, branch=0: ->REQ (fetch pc).
//   instTaken=1, branch=1: pc<=branchAddr, ->REQ.
//   branch without instTaken is ignored.
//  memAck outside REQ is ignored. instTaken while !instValid is ignored.
//  PC arithmetic: ADDR_W-bit unsigned. pc+1 wraps 2^ADDR_W-1 -> 0.
//  Peak throughput is 1 instruction per 2 cycles (no prefetch).
//  memAddr always equals pc, including outside REQ.
// CONFIGURATION
//  HALT_EN defined: when a fetched instruction equals 8'hFF, it is presented
//   in VALID as normal. On instTaken the block moves to HALT instead of REQ,
//   and branch is ignored. HALT: memReq=0, instValid=0, inst=8'h00,
//   halted=1, pc frozen. The only exit is reset.
//  HALT_EN undefined: 8'hFF is an ordinary instruction, the HALT state does
//   not exist, and halted is tied to 0.
// TESTING
//  1 Reset: rstN=0 with memAck=1, memData=8'hAA -> memReq=0, instValid=0,
//    inst=8'h00, memAddr=PC_RESET; after release, memReq=1 on the next cycle.
//  2 Sequential fetch, zero-wait mem returning mem[a]=a+8'h10, instTaken
//    held 1 -> inst 8'h10,8'h11,8'h12 on alternate cycles; memAddr 0,1,2.
//  3 Wait states: memAck delayed 3 cycles -> memReq and memAddr stable
//    throughout; instValid rises 1 cycle after the ack edge.
//  4 Backpressure plus branch: instValid=1, instTaken=0 for 4 cycles with
//    branch=1 -> inst held, pc unchanged; then instTaken=1, branch=1,
//    branchAddr=8'h40 -> next memAddr=8'h40.
//  5 Wrap and reset mid-fetch: PC_RESET=8'hFF -> fetch at 8'hFF, then 8'h00.
//    Pull rstN low while memReq=1 -> memReq falls immediately, pc=8'hFF.
//  6 HALT_EN: fetch 8'hFF, instTaken=1 -> halted=1, memReq stays 0 for
//    10 cycles, inst=8'h00; without HALT_EN, 8'hFF is followed by a fetch at pc+1.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory req/ack port plus the decode-side
// instruction/branch handshake. master = fetch unit, slave = memory/decode side.
interface instruction_fetch_if #(
  parameter int unsigned ADDR_W = 8
);
  logic [ADDR_W-1:0] memAddr;
  logic              memReq;
  logic              memAck;
  logic [7:0]        memData;
  logic [7:0]        inst;
  logic              instValid;
  logic              instTaken;
  logic              branch;
  logic [ADDR_W-1:0] branchAddr;
  logic              halted;

  modport master (
    output memAddr, memReq, inst, instValid, halted,
    input  memAck, memData, instTaken, branch, branchAddr
  );

  modport slave (
    input  memAddr, memReq, inst, instValid, halted,
    output memAck, memData, instTaken, branch, branchAddr
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction sequencer: PC, req/ack fetch from instruction memory, and holding
// of the fetched byte for decode. Define HALT_EN to make 8'hFF a halt opcode.
module instruction_fetch #(
  parameter int unsigned       ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
  input  logic                clk,
  input  logic                rstN,
  instruction_fetch_if.master bus
);

`ifdef HALT_EN
  typedef enum logic [1:0] {S_REQ, S_VALID, S_HALT} state_t;
`else
  typedef enum logic [1:0] {S_REQ, S_VALID} state_t;
`endif

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [7:0]        r_instReg;
  logic              r_memReq;
  logic              r_instValid;
  logic              w_accept;
`ifdef HALT_EN
  logic              r_halted;
`endif

  // memReq is registered low out of reset, so the first REQ cycle after
  // release cannot accept an ack; acceptance is gated by the visible request.
  assign w_accept = r_memReq & bus.memAck;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state     <= S_REQ;
      r_pc        <= PC_RESET;
      r_instReg   <= '0;
      r_memReq    <= 1'b0;
      r_instValid <= 1'b0;
`ifdef HALT_EN
      r_halted    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_REQ: begin
          if (w_accept) begin
            r_instReg   <= bus.memData;
            r_pc        <= r_pc + 1'b1;
            r_memReq    <= 1'b0;
            r_instValid <= 1'b1;
            r_state     <= S_VALID;
          end else begin
            r_memReq <= 1'b1;
          end
        end
        S_VALID: begin
          if (bus.instTaken) begin
`ifdef HALT_EN
            if (r_instReg == 8'hFF) begin
              r_instValid <= 1'b0;
              r_halted    <= 1'b1;
              r_state     <= S_HALT;
            end else
`endif
            begin
              if (bus.branch) r_pc <= bus.branchAddr;
              r_instValid <= 1'b0;
              r_memReq    <= 1'b1;
              r_state     <= S_REQ;
            end
          end
        end
`ifdef HALT_EN
        S_HALT: begin
          r_state <= S_HALT;
        end
`endif
        default: begin
          r_state <= S_REQ;
        end
      endcase
    end
  end

  // Reset also kills the request combinationally so an in-flight fetch drops at once.
  assign bus.memReq    = r_memReq & rstN;
  assign bus.memAddr   = r_pc;
  assign bus.instValid = r_instValid;
  assign bus.inst      = r_instValid ? r_instReg : 8'h00;
`ifdef HALT_EN
  assign bus.halted    = r_halted;
`else
  assign bus.halted    = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus a random
// run checked against a transaction-level fetch/consume model.
module tb_instruction_fetch;

  logic clk = 1'b0;
  logic rstN0 = 1'b0;
  logic rstN1 = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [7:0] held_inst;
  logic [7:0] mem [256];

  always #5 clk = ~clk;

  instruction_fetch_if #(.ADDR_W(8)) if0 ();
  instruction_fetch_if #(.ADDR_W(8)) if1 ();

  instruction_fetch #(.ADDR_W(8), .PC_RESET(8'h00)) u_dut0 (
    .clk(clk), .rstN(rstN0), .bus(if0.master)
  );

  instruction_fetch #(.ADDR_W(8), .PC_RESET(8'hFF)) u_dut1 (
    .clk(clk), .rstN(rstN1), .bus(if1.master)
  );

  task automatic test_reset();
    rstN0 = 1'b0; if0.memAck = 1'b1; if0.memData = 8'hAA; if0.instTaken = 1'b0;
    repeat (2) @(negedge clk);
    if (if0.memReq !== 1'b0)     begin $display("FAIL reset_memReq got %b want 0", if0.memReq); n_fail++; end n_checks++;
    if (if0.instValid !== 1'b0)  begin $display("FAIL reset_instValid got %b want 0", if0.instValid); n_fail++; end n_checks++;
    if (if0.inst !== 8'h00)      begin $display("FAIL reset_inst got %h want 00", if0.inst); n_fail++; end n_checks++;
    if (if0.memAddr !== 8'h00)   begin $display("FAIL reset_memAddr got %h want 00", if0.memAddr); n_fail++; end n_checks++;
    if (if0.halted !== 1'b0)     begin $display("FAIL reset_halted got %b want 0", if0.halted); n_fail++; end n_checks++;
    if0.memAck = 1'b0;
    rstN0 = 1'b1;
    #1;
    if (if0.memReq !== 1'b0)     begin $display("FAIL release_memReq_before_edge got %b want 0", if0.memReq); n_fail++; end n_checks++;
    @(negedge clk);
    if (if0.memReq !== 1'b1)     begin $display("FAIL release_memReq_next got %b want 1", if0.memReq); n_fail++; end n_checks++;
    if (if0.memAddr !== 8'h00)   begin $display("FAIL release_memAddr got %h want 00", if0.memAddr); n_fail++; end n_checks++;
  endtask

  task automatic test_sequential();
    logic [7:0] a;
    if0.instTaken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = 8'(i);
      if (if0.memReq !== 1'b1) begin $display("FAIL seq_memReq[%0d] got %b want 1", i, if0.memReq); n_fail++; end n_checks++;
      if (if0.memAddr !== a)   begin $display("FAIL seq_memAddr[%0d] got %h want %h", i, if0.memAddr, a); n_fail++; end n_checks++;
      if0.memAck = 1'b1; if0.memData = a + 8'h10;
      @(negedge clk);
      if (if0.instValid !== 1'b1)    begin $display("FAIL seq_instValid[%0d] got %b want 1", i, if0.instValid); n_fail++; end n_checks++;
      if (if0.inst !== a + 8'h10)    begin $display("FAIL seq_inst[%0d] got %h want %h", i, if0.inst, a + 8'h10); n_fail++; end n_checks++;
      if (if0.memReq !== 1'b0)       begin $display("FAIL seq_memReq_valid[%0d] got %b want 0", i, if0.memReq); n_fail++; end n_checks++;
      if0.memAck = 1'b0;
      @(negedge clk);
    end
    if0.instTaken = 1'b0;
  endtask

  task automatic test_wait_states();
    logic [7:0] d;
    for (int k = 0; k < 3; k++) begin
      if0.memAck = 1'b0; if0.memData = 8'($urandom);
      @(negedge clk);
      if (if0.memReq !== 1'b1)    begin $display("FAIL wait_memReq[%0d] got %b want 1", k, if0.memReq); n_fail++; end n_checks++;
      if (if0.memAddr !== 8'h03)  begin $display("FAIL wait_memAddr[%0d] got %h want 03", k, if0.memAddr); n_fail++; end n_checks++;
      if (if0.instValid !== 1'b0) begin $display("FAIL wait_instValid[%0d] got %b want 0", k, if0.instValid); n_fail++; end n_checks++;
    end
    d = 8'($urandom_range(0, 254));
    if0.memAck = 1'b1; if0.memData = d;
    @(negedge clk);
    if (if0.instValid !== 1'b1) begin $display("FAIL wait_ack_instValid got %b want 1", if0.instValid); n_fail++; end n_checks++;
    if (if0.inst !== d)         begin $display("FAIL wait_ack_inst got %h want %h", if0.inst, d); n_fail++; end n_checks++;
    if0.memAck = 1'b0;
    held_inst = d;
  endtask

  task automatic test_backpressure_branch();
    for (int k = 0; k < 4; k++) begin
      if0.instTaken = 1'b0; if0.branch = 1'b1; if0.branchAddr = 8'($urandom);
      if0.memAck = 1'($urandom);
      @(negedge clk);
      if (if0.inst !== held_inst)  begin $display("FAIL bp_inst[%0d] got %h want %h", k, if0.inst, held_inst); n_fail++; end n_checks++;
      if (if0.instValid !== 1'b1)  begin $display("FAIL bp_instValid[%0d] got %b want 1", k, if0.instValid); n_fail++; end n_checks++;
      if (if0.memAddr !== 8'h04)   begin $display("FAIL bp_pc[%0d] got %h want 04", k, if0.memAddr); n_fail++; end n_checks++;
      if (if0.memReq !== 1'b0)     begin $display("FAIL bp_memReq[%0d] got %b want 0", k, if0.memReq); n_fail++; end n_checks++;
    end
    if0.memAck = 1'b0; if0.instTaken = 1'b1; if0.branch = 1'b1; if0.branchAddr = 8'h40;
    @(negedge clk);
    if (if0.memReq !== 1'b1)    begin $display("FAIL branch_memReq got %b want 1", if0.memReq); n_fail++; end n_checks++;
    if (if0.memAddr !== 8'h40)  begin $display("FAIL branch_memAddr got %h want 40", if0.memAddr); n_fail++; end n_checks++;
    if (if0.instValid !== 1'b0) begin $display("FAIL branch_instValid got %b want 0", if0.instValid); n_fail++; end n_checks++;
    if (if0.inst !== 8'h00)     begin $display("FAIL branch_inst_nop got %h want 00", if0.inst); n_fail++; end n_checks++;
    if0.instTaken = 1'b0; if0.branch = 1'b0;
  endtask

  task automatic test_wrap_reset();
    if1.memAck = 1'b0; if1.memData = 8'h00; if1.instTaken = 1'b0;
    if1.branch = 1'b0; if1.branchAddr = 8'h00;
    rstN1 = 1'b1;
    @(negedge clk);
    if (if1.memReq !== 1'b1)    begin $display("FAIL wrap_memReq got %b want 1", if1.memReq); n_fail++; end n_checks++;
    if (if1.memAddr !== 8'hFF)  begin $display("FAIL wrap_first_addr got %h want ff", if1.memAddr); n_fail++; end n_checks++;
    if1.memAck = 1'b1; if1.memData = 8'h5A;
    @(negedge clk);
    if (if1.inst !== 8'h5A)     begin $display("FAIL wrap_inst got %h want 5a", if1.inst); n_fail++; end n_checks++;
    if (if1.memAddr !== 8'h00)  begin $display("FAIL wrap_pc got %h want 00", if1.memAddr); n_fail++; end n_checks++;
    if1.memAck = 1'b0; if1.instTaken = 1'b1;
    @(negedge clk);
    if (if1.memReq !== 1'b1)    begin $display("FAIL wrap_second_req got %b want 1", if1.memReq); n_fail++; end n_checks++;
    if (if1.memAddr !== 8'h00)  begin $display("FAIL wrap_second_addr got %h want 00", if1.memAddr); n_fail++; end n_checks++;
    if1.instTaken = 1'b0;
    @(negedge clk);
    rstN1 = 1'b0;
    #1;
    if (if1.memReq !== 1'b0)    begin $display("FAIL midfetch_memReq got %b want 0", if1.memReq); n_fail++; end n_checks++;
    if (if1.memAddr !== 8'hFF)  begin $display("FAIL midfetch_pc got %h want ff", if1.memAddr); n_fail++; end n_checks++;
    @(negedge clk);
  endtask

  task automatic test_halt();
    if0.memAck = 1'b1; if0.memData = 8'hFF;
    @(negedge clk);
    if (if0.instValid !== 1'b1) begin $display("FAIL ff_instValid got %b want 1", if0.instValid); n_fail++; end n_checks++;
    if (if0.inst !== 8'hFF)     begin $display("FAIL ff_inst got %h want ff", if0.inst); n_fail++; end n_checks++;
    if0.memAck = 1'b0; if0.instTaken = 1'b1;
`ifdef HALT_EN
    if0.branch = 1'b1; if0.branchAddr = 8'h10;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if0.memAck = 1'($urandom);
      if (if0.halted !== 1'b1)    begin $display("FAIL halt_halted[%0d] got %b want 1", k, if0.halted); n_fail++; end n_checks++;
      if (if0.memReq !== 1'b0)    begin $display("FAIL halt_memReq[%0d] got %b want 0", k, if0.memReq); n_fail++; end n_checks++;
      if (if0.instValid !== 1'b0) begin $display("FAIL halt_instValid[%0d] got %b want 0", k, if0.instValid); n_fail++; end n_checks++;
      if (if0.inst !== 8'h00)     begin $display("FAIL halt_inst[%0d] got %h want 00", k, if0.inst); n_fail++; end n_checks++;
      if (if0.memAddr !== 8'h41)  begin $display("FAIL halt_pc[%0d] got %h want 41", k, if0.memAddr); n_fail++; end n_checks++;
    end
`else
    if0.branch = 1'b0;
    @(negedge clk);
    if (if0.memReq !== 1'b1)    begin $display("FAIL ff_next_memReq got %b want 1", if0.memReq); n_fail++; end n_checks++;
    if (if0.memAddr !== 8'h41)  begin $display("FAIL ff_next_addr got %h want 41", if0.memAddr); n_fail++; end n_checks++;
    if (if0.halted !== 1'b0)    begin $display("FAIL ff_halted got %b want 0", if0.halted); n_fail++; end n_checks++;
`endif
    if0.memAck = 1'b0; if0.instTaken = 1'b0; if0.branch = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0] exp_pc;
    logic [7:0] exp_inst;
    logic       exp_have;
    logic       ack, taken, br;
    logic [7:0] baddr;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 254));
    rstN0 = 1'b0;
    @(negedge clk);
    if (if0.halted !== 1'b0) begin $display("FAIL rand_reset_halted got %b want 0", if0.halted); n_fail++; end n_checks++;
    rstN0 = 1'b1;
    @(negedge clk);
    exp_pc = 8'h00; exp_inst = 8'h00; exp_have = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (if0.memAddr !== exp_pc)      begin $display("FAIL rand_memAddr[%0d] got %h want %h", n, if0.memAddr, exp_pc); n_fail++; end n_checks++;
      if (if0.memReq !== !exp_have)    begin $display("FAIL rand_memReq[%0d] got %b want %b", n, if0.memReq, !exp_have); n_fail++; end n_checks++;
      if (if0.instValid !== exp_have)  begin $display("FAIL rand_instValid[%0d] got %b want %b", n, if0.instValid, exp_have); n_fail++; end n_checks++;
      if (if0.inst !== (exp_have ? exp_inst : 8'h00)) begin
        $display("FAIL rand_inst[%0d] got %h want %h", n, if0.inst, exp_have ? exp_inst : 8'h00); n_fail++;
      end
      n_checks++;
      ack = 1'($urandom); taken = 1'($urandom); br = ($urandom_range(0, 3) == 0); baddr = 8'($urandom);
      if0.memAck = ack; if0.memData = mem[if0.memAddr];
      if0.instTaken = taken; if0.branch = br; if0.branchAddr = baddr;
      if (!exp_have && ack) begin
        exp_inst = mem[exp_pc]; exp_pc = exp_pc + 8'h01; exp_have = 1'b1;
      end else if (exp_have && taken) begin
        if (br) exp_pc = baddr;
        exp_have = 1'b0;
      end
      @(negedge clk);
    end
    if0.memAck = 1'b0; if0.instTaken = 1'b0; if0.branch = 1'b0;
  endtask

  initial begin
    if0.memAck = 1'b0; if0.memData = 8'h00; if0.instTaken = 1'b0;
    if0.branch = 1'b0; if0.branchAddr = 8'h00;
    if1.memAck = 1'b0; if1.memData = 8'h00; if1.instTaken = 1'b0;
    if1.branch = 1'b0; if1.branchAddr = 8'h00;
    @(negedge clk);
    test_reset();
    test_sequential();
    test_wait_states();
    test_backpressure_branch();
    test_halt();
    test_wrap_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
